pe_sparse_mac: RTL and testbench
================================

# pe_sparse_mac

Consumes the per-cycle compressed-buffer offsets produced by the flag-offset stage and turns them into absolute read addresses for the compressed activation and weight scratchpads. It fetches each matched nonzero activation/weight pair and multiply-accumulates it into a partial sum. It sits directly downstream of the flag-offset stage inside each PE and shares that stage's start pulse. It reports completion once the last matched pair of a flag block has been accumulated.

## Interface
Parameters:
- DATA_WIDTH, 32: flag block depth (bits per flag word upstream).
- ADDR_WIDTH, 5: scratchpad address width; log2(DATA_WIDTH).
- ACT_WIDTH, 8: signed activation width.
- WEI_WIDTH, 8: signed weight width.
- PSUM_WIDTH, 24: accumulator width.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  block start; the same pulse the flag-offset stage uses to load its flags.
- offset_act  in  ADDR_WIDTH+1  activation offset for the current match; 0 means no match.
- offset_wei  in  ADDR_WIDTH+1  weight offset for the current match; 0 means no match.
- act_rd_en  out  1  activation scratchpad read strobe.
- act_rd_addr  out  ADDR_WIDTH  activation read address.
- act_rd_data  in  ACT_WIDTH  activation read data; valid 1 cycle after act_rd_en.
- wei_rd_en  out  1  weight read strobe.
- wei_rd_addr  out  ADDR_WIDTH  weight read address.
- wei_rd_data  in  WEI_WIDTH  weight read data; valid 1 cycle after wei_rd_en.
- psum_clr  in  1  clears the accumulator.
- psum  out  PSUM_WIDTH  accumulated partial sum, signed.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when psum is final for the block.

## Operation
- FSM states: IDLE, WAIT, RUN, DRAIN, DONE.
  - IDLE→WAIT on start.
  - WAIT→RUN after one cycle; this covers the 2-cycle offset-stage fill.
  - RUN→DRAIN when offset_act==0 or offset_wei==0.
  - DRAIN→DONE after one cycle.
  - DONE→IDLE after one cycle.
- On start: base_act and base_wei (each ADDR_WIDTH+1 bits) are cleared to 0, and any in-flight read or product is squashed (not accumulated).
- RUN, both offsets nonzero:
  - act_rd_addr = base_act + offset_act − 1, and likewise for wei.
  - act_rd_en = wei_rd_en = 1.
  - base_act += offset_act, and likewise for wei.
- RUN, either offset zero: no read is issued. Only both-nonzero counts as a match.
- Pipeline: the read is issued in cycle k, data arrives in k+1, the signed product (ACT_WIDTH+WEI_WIDTH bits) is registered at the end of k+1, and it is accumulated at the end of k+2.
- Accumulate: psum ← (psum_clr ? 0 : psum) + (prod_valid ? sign-extended product : 0). Wraps modulo 2^PSUM_WIDTH with no saturation.
- psum persists across blocks and is cleared only by psum_clr or rst.
- start in any state (including mid-RUN) restarts the block. psum is not cleared by start.
- Reset values: act_rd_en=0, wei_rd_en=0, act_rd_addr=0, wei_rd_addr=0, psum=0, busy=0, done=0, state=IDLE, bases=0, prod_valid=0.
- rst mid-block aborts everything the same cycle; no done is produced.

## Timing
- Cycle 0 is start sampled high. WAIT is cycle 1. RUN begins in cycle 2, the first cycle the offsets are valid.
- With N matches (0 ≤ N ≤ DATA_WIDTH):
  - reads are issued in cycles 2..N+1;
  - the zero offset is seen in cycle N+2;
  - DRAIN is cycle N+3;
  - DONE (done=1, psum final) is cycle N+4.
- Reads are back-to-back, one per cycle, with no bubbles.
- busy is high in cycles 1..N+4.
- N=0 gives done in cycle 4 with psum unchanged.
- N=DATA_WIDTH gives done in cycle 36 for the defaults.
- The maximum address is DATA_WIDTH−1. The base never exceeds DATA_WIDTH.

## Structure
- Shared package holds the FSM state enum, the default width constants, and the product width (ACT_WIDTH+WEI_WIDTH).
- One sub-module, pe_mac_pipe, contains the product register, prod_valid, the squash input and the accumulator with clear.
- The top level holds the FSM and address generation.

## Test plan
- Act flags = wei flags = 0x0000_0005: offsets (1,1),(2,2),0. Act mem[0]=3, mem[1]=−2; wei mem[0]=4, mem[1]=5. Required: reads at addresses 0 then 1, psum=2, done in cycle 6.
- Disjoint flags, so offsets are 0 from cycle 2: no reads, done in cycle 4, psum unchanged.
- All-ones flags with all data = 1: 32 reads at addresses 0..31 in consecutive cycles, psum=32, done in cycle 36.
- Two blocks with no psum_clr between them, each giving 10: psum=20. Then a psum_clr pulse gives psum=0.
- Second start in cycle 5 of a long block: in-flight products are dropped, addresses restart at 0, and only one done fires, for the second block.
- rst in cycle 3 of RUN: the next cycle shows all outputs at reset values and no done.
- act=−128 and wei=−128 accumulated 512 times in 16 blocks of 32: psum=0x800000, the sign wrap at 24 bits.

Source files
------------

// File: rtl/pe_sparse_mac_pkg.sv
// Shared definitions for the sparse MAC stage of a PE.
// Holds the sequencing FSM states, the default widths and the product-width helper.
package pe_sparse_mac_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_ACT_WIDTH  = 8;
  localparam int DEF_WEI_WIDTH  = 8;
  localparam int DEF_PSUM_WIDTH = 24;
  localparam int DEF_PROD_WIDTH = DEF_ACT_WIDTH + DEF_WEI_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RUN,
    DRAIN,
    DONE
  } MacState;

  // A signed a*b product needs exactly a+b bits.
  function automatic int prodWidth(input int actWidth, input int weiWidth);
    return actWidth + weiWidth;
  endfunction

endpackage

// File: rtl/pe_mac_pipe.sv
// Read-data multiply and accumulate pipeline for the sparse MAC.
// Tracks each issued read through the product register into the wrapping accumulator.
module pe_mac_pipe
  import pe_sparse_mac_pkg::*;
#(
  parameter int ACT_WIDTH  = DEF_ACT_WIDTH,
  parameter int WEI_WIDTH  = DEF_WEI_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdIssue,
  input  logic                         squash,
  input  logic signed [ACT_WIDTH-1:0]  actData,
  input  logic signed [WEI_WIDTH-1:0]  weiData,
  input  logic                         psumClr,
  output logic        [PSUM_WIDTH-1:0] psum
);

  localparam int PROD_WIDTH = prodWidth(ACT_WIDTH, WEI_WIDTH);

  logic                         rdPending;
  logic                         prodValid;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [PROD_WIDTH-1:0] prodNext;
  logic signed [PSUM_WIDTH-1:0] prodExt;
  logic signed [PSUM_WIDTH-1:0] acc;
  logic signed [PSUM_WIDTH-1:0] accBase;
  logic signed [PSUM_WIDTH-1:0] accAdd;

  assign prodNext = PROD_WIDTH'(actData) * PROD_WIDTH'(weiData);
  assign prodExt  = PSUM_WIDTH'(prod);

  // A squash drops both the read whose data is arriving and the product about to be summed.
  always_comb begin
    accBase = psumClr ? '0 : acc;
    accAdd  = (prodValid && !squash) ? prodExt : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPending <= 1'b0;
      prodValid <= 1'b0;
      prod      <= '0;
      acc       <= '0;
    end else begin
      rdPending <= rdIssue && !squash;
      prodValid <= rdPending && !squash;
      prod      <= prodNext;
      acc       <= accBase + accAdd;
    end
  end

  assign psum = acc;

endmodule

// File: rtl/pe_sparse_mac.sv
// Sparse MAC stage: turns flag-offset stage offsets into scratchpad reads
// and accumulates each matched activation/weight product into psum.
module pe_sparse_mac
  import pe_sparse_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ACT_WIDTH  = DEF_ACT_WIDTH,
  parameter int WEI_WIDTH  = DEF_WEI_WIDTH,
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   offset_act,
  input  logic [ADDR_WIDTH:0]   offset_wei,
  output logic                  act_rd_en,
  output logic [ADDR_WIDTH-1:0] act_rd_addr,
  input  logic [ACT_WIDTH-1:0]  act_rd_data,
  output logic                  wei_rd_en,
  output logic [ADDR_WIDTH-1:0] wei_rd_addr,
  input  logic [WEI_WIDTH-1:0]  wei_rd_data,
  input  logic                  psum_clr,
  output logic [PSUM_WIDTH-1:0] psum,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] ONE      = 1;
  localparam logic [ADDR_WIDTH:0] MAX_BASE = (ADDR_WIDTH + 1)'(DATA_WIDTH);

  MacState             state;
  MacState             nextState;
  logic [ADDR_WIDTH:0] baseAct;
  logic [ADDR_WIDTH:0] baseWei;
  logic [ADDR_WIDTH:0] actLast;
  logic [ADDR_WIDTH:0] weiLast;
  logic                match;
  logic                issue;

  assign match   = (offset_act != '0) && (offset_wei != '0);
  assign issue   = (state == RUN) && match && !start;
  assign actLast = baseAct + offset_act - ONE;
  assign weiLast = baseWei + offset_wei - ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // WAIT absorbs the offset stage's fill; a start from any state restarts the block.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = IDLE;
      WAIT:    nextState = RUN;
      RUN:     nextState = match ? RUN : DRAIN;
      DRAIN:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (start) begin
      nextState = WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      baseAct <= '0;
      baseWei <= '0;
    end else if (issue) begin
      baseAct <= baseAct + offset_act;
      baseWei <= baseWei + offset_wei;
    end
  end

  always_comb begin
    act_rd_en   = issue;
    wei_rd_en   = issue;
    act_rd_addr = '0;
    wei_rd_addr = '0;
    if (issue) begin
      act_rd_addr = actLast[ADDR_WIDTH-1:0];
      wei_rd_addr = weiLast[ADDR_WIDTH-1:0];
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  pe_mac_pipe #(
    .ACT_WIDTH (ACT_WIDTH),
    .WEI_WIDTH (WEI_WIDTH),
    .PSUM_WIDTH(PSUM_WIDTH)
  ) macPipe (
    .clk    (clk),
    .rst    (rst),
    .rdIssue(issue),
    .squash (start),
    .actData(act_rd_data),
    .weiData(wei_rd_data),
    .psumClr(psum_clr),
    .psum   (psum)
  );

  // A well-formed offset stream never walks a base past the end of the flag block.
  assert property (@(posedge clk) disable iff (rst)
    (baseAct <= MAX_BASE) && (baseWei <= MAX_BASE));

endmodule

// File: tb/tb_pe_sparse_mac.sv
// Self-checking bench for pe_sparse_mac: emulates the flag-offset stage and
// scratchpads, and predicts addresses, timing and psum from the flag words.
module tb_pe_sparse_mac;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int ACTW = 8;
  localparam int WEIW = 8;
  localparam int PSW  = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW:0]     offset_act;
  logic [AW:0]     offset_wei;
  logic            act_rd_en;
  logic [AW-1:0]   act_rd_addr;
  logic [ACTW-1:0] act_rd_data = '0;
  logic            wei_rd_en;
  logic [AW-1:0]   wei_rd_addr;
  logic [WEIW-1:0] wei_rd_data = '0;
  logic            psum_clr;
  logic [PSW-1:0]  psum;
  logic            busy;
  logic            done;

  logic signed [ACTW-1:0] actMem [DW];
  logic signed [WEIW-1:0] weiMem [DW];

  int checks = 0;
  int errors = 0;
  int modelPsum = 0;

  pe_sparse_mac #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACT_WIDTH(ACTW), .WEI_WIDTH(WEIW), .PSUM_WIDTH(PSW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .offset_act(offset_act), .offset_wei(offset_wei),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .wei_rd_en(wei_rd_en), .wei_rd_addr(wei_rd_addr), .wei_rd_data(wei_rd_data),
    .psum_clr(psum_clr), .psum(psum), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered-read scratchpads: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (act_rd_en) act_rd_data <= actMem[act_rd_addr];
    if (wei_rd_en) wei_rd_data <= weiMem[wei_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fillMem(input int mode, input int actVal, input int weiVal);
    for (int i = 0; i < DW; i++) begin
      actMem[i] = (mode == 0) ? ACTW'(actVal) : ACTW'($urandom());
      weiMem[i] = (mode == 0) ? WEIW'(weiVal) : WEIW'($urandom());
    end
  endtask

  task automatic clearPsum();
    psum_clr = 1'b1;
    nextCycle();
    psum_clr = 1'b0;
    modelPsum = 0;
    checkOutput("psumClr", 32'(psum), 32'd0);
  endtask

  // One block: start in cycle 0, offsets from cycle 2. abortAt >= 0 ends the block
  // at that cycle, either by returning so the caller's next start lands there, or by rst.
  task automatic applyStimulus(input logic [31:0] actFlags, input logic [31:0] weiFlags,
                               input int abortAt, input bit abortByReset);
    int aIdx[$];
    int wIdx[$];
    int n;
    int m;
    int baseA;
    int baseW;
    bit rdExp;
    logic [31:0] mask;
    for (int p = 0; p < DW; p++) begin
      mask = (32'd1 << p) - 32'd1;
      if (actFlags[p] && weiFlags[p]) begin
        aIdx.push_back($countones(actFlags & mask));
        wIdx.push_back($countones(weiFlags & mask));
      end
    end
    n = aIdx.size();
    baseA = 0;
    baseW = 0;
    start = 1'b1;
    offset_act = '0;
    offset_wei = '0;
    nextCycle();
    start = 1'b0;
    for (int c = 1; c <= n + 5; c++) begin
      if (abortAt >= 0 && c == abortAt) begin
        offset_act = '0;
        offset_wei = '0;
        if (abortByReset) begin
          rst = 1'b1;
          nextCycle();
          rst = 1'b0;
          modelPsum = 0;
          checkOutput("rstBusy", 32'(busy), 32'd0);
          checkOutput("rstDone", 32'(done), 32'd0);
          checkOutput("rstPsum", 32'(psum), 32'd0);
          checkOutput("rstActEn", 32'(act_rd_en), 32'd0);
          checkOutput("rstWeiEn", 32'(wei_rd_en), 32'd0);
          checkOutput("rstActAddr", 32'(act_rd_addr), 32'd0);
          checkOutput("rstWeiAddr", 32'(wei_rd_addr), 32'd0);
          for (int k = 0; k < 4; k++) begin
            nextCycle();
            checkOutput("rstNoDone", 32'(done), 32'd0);
          end
        end
        return;
      end
      m = c - 2;
      rdExp = (m >= 0) && (m < n);
      if (rdExp) begin
        offset_act = (AW + 1)'(aIdx[m] + 1 - baseA);
        offset_wei = (AW + 1)'(wIdx[m] + 1 - baseW);
        baseA = aIdx[m] + 1;
        baseW = wIdx[m] + 1;
        if (abortAt < 0 || c + 2 < abortAt)
          modelPsum += int'(actMem[aIdx[m]]) * int'(weiMem[wIdx[m]]);
      end else begin
        offset_act = '0;
        offset_wei = '0;
      end
      #1;
      checkOutput("busy", 32'(busy), 32'(c <= n + 4));
      checkOutput("done", 32'(done), 32'(c == n + 4));
      checkOutput("actRdEn", 32'(act_rd_en), 32'(rdExp));
      checkOutput("weiRdEn", 32'(wei_rd_en), 32'(rdExp));
      checkOutput("actRdAddr", 32'(act_rd_addr), rdExp ? 32'(aIdx[m]) : 32'd0);
      checkOutput("weiRdAddr", 32'(wei_rd_addr), rdExp ? 32'(wIdx[m]) : 32'd0);
      if (c >= n + 4)
        checkOutput("psum", 32'(psum), 32'(modelPsum & 32'hFF_FFFF));
      nextCycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    psum_clr = 1'b0;
    offset_act = '0;
    offset_wei = '0;
    fillMem(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetPsum", 32'(psum), 32'd0);
    checkOutput("resetActEn", 32'(act_rd_en), 32'd0);
    checkOutput("resetActAddr", 32'(act_rd_addr), 32'd0);
    rst = 1'b0;
    nextCycle();

    actMem[0] = 8'sd3;
    actMem[1] = -8'sd2;
    weiMem[0] = 8'sd4;
    weiMem[1] = 8'sd5;
    applyStimulus(32'h0000_0005, 32'h0000_0005, -1, 1'b0);
    checkOutput("directedPsum", 32'(psum), 32'd2);

    applyStimulus(32'h0000_000F, 32'h0000_00F0, -1, 1'b0);
    checkOutput("noMatchPsum", 32'(psum), 32'd2);

    fillMem(0, 1, 1);
    clearPsum();
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    checkOutput("fullBlockPsum", 32'(psum), 32'd32);

    clearPsum();
    fillMem(0, 2, 5);
    applyStimulus(32'h0000_0001, 32'h0000_0001, -1, 1'b0);
    applyStimulus(32'h0000_0001, 32'h0000_0001, -1, 1'b0);
    checkOutput("twoBlockPsum", 32'(psum), 32'd20);
    clearPsum();

    fillMem(1, 0, 0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
    applyStimulus($urandom() | 32'h1, $urandom() | 32'h1, -1, 1'b0);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b1);

    fillMem(0, -128, -128);
    clearPsum();
    for (int b = 0; b < 16; b++)
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    checkOutput("wrapPsum", 32'(psum), 32'h0080_0000);

    for (int r = 0; r < 8; r++) begin
      fillMem(1, 0, 0);
      if (r == 4) clearPsum();
      applyStimulus($urandom() & $urandom(), $urandom() | $urandom(), -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
